mux_scan_sel: RTL and testbench



---
 rtl/mux_scan_sel.sv | 149 ++++++++++++++
 tb/tb_mux_scan_sel.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_sel.sv
// mux_scan_sel: N-channel, W-bit registered multiplexer with two modes.
//   Direct mode (mode=0): clocked data selector, z <= data_in[sel] each
//   cycle while en_n is low.
//   Scan mode (mode=1): a start pulse in IDLE snapshots every channel.
//   The snapshot is then streamed one channel per accepted handshake on
//   z/z_valid/z_ready. done pulses after the last word is accepted.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   en_n          active-low enable; raising it mid-scan aborts the scan
//   mode, sel     mode select and direct-mode channel select
//   start         begins a scan (sampled in IDLE only)
//   data_in       channel i at bits [i*WIDTH +: WIDTH]
//   z, z_n        registered output and its bitwise complement
//   z_valid       z holds valid data
//   z_ready       downstream accepts z (scan mode only)
//   ch            index of the channel currently on z
//   busy, done    scan in progress / one-cycle completion pulse
module mux_scan_sel #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en_n,
  input  logic                        mode,
  input  logic [$clog2(CHANNELS)-1:0] sel,
  input  logic                        start,
  input  logic [CHANNELS*WIDTH-1:0]   data_in,
  output logic [WIDTH-1:0]            z,
  output logic [WIDTH-1:0]            z_n,
  output logic                        z_valid,
  input  logic                        z_ready,
  output logic [$clog2(CHANNELS)-1:0] ch,
  output logic                        busy,
  output logic                        done
);

  localparam int SEL_W = $clog2(CHANNELS);
  localparam logic [SEL_W-1:0] CH_LAST = SEL_W'(CHANNELS - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                      state_q, state_d;
  logic [WIDTH-1:0]            z_q, z_d;
  logic                        z_valid_q, z_valid_d;
  logic [SEL_W-1:0]            ch_q, ch_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic [CHANNELS*WIDTH-1:0]   snap_q, snap_d;

  // Channel extraction that yields zero for indices past the last channel,
  // so non-power-of-two banks never index outside the vector.
  function automatic logic [WIDTH-1:0] pick(
    input logic [CHANNELS*WIDTH-1:0] vec,
    input logic [SEL_W-1:0]          idx
  );
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (idx == SEL_W'(i)) r = vec[i*WIDTH +: WIDTH];
    end
    return r;
  endfunction

  always_comb begin
    state_d   = state_q;
    z_d       = z_q;
    z_valid_d = z_valid_q;
    ch_d      = ch_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    snap_d    = snap_q;
    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (en_n) begin
          z_d       = '0;
          z_valid_d = 1'b0;
        end else if (!mode) begin
          z_d       = pick(data_in, sel);
          ch_d      = sel;
          z_valid_d = 1'b1;
        end else if (!start) begin
          z_d       = '0;
          z_valid_d = 1'b0;
        end else begin
          // First word goes out on the same edge that captures the snapshot.
          snap_d    = data_in;
          z_d       = data_in[WIDTH-1:0];
          ch_d      = '0;
          z_valid_d = 1'b1;
          busy_d    = 1'b1;
          state_d   = SCAN;
        end
      end
      SCAN: begin
        if (en_n) begin
          z_d       = '0;
          z_valid_d = 1'b0;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end else if (z_valid_q && z_ready) begin
          if (ch_q != CH_LAST) begin
            ch_d = ch_q + 1'b1;
            z_d  = pick(snap_q, ch_q + 1'b1);
          end else begin
            z_d       = '0;
            z_valid_d = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      z_q       <= '0;
      z_valid_q <= 1'b0;
      ch_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      z_q       <= z_d;
      z_valid_q <= z_valid_d;
      ch_q      <= ch_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Snapshot is only meaningful while in SCAN, so it needs no reset.
  always_ff @(posedge clk) begin
    snap_q <= snap_d;
  end

  assign z       = z_q;
  assign z_n     = ~z_q;
  assign z_valid = z_valid_q;
  assign ch      = ch_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_mux_scan_sel.sv
module tb_mux_scan_sel;

  localparam int W  = 4;
  localparam int CH = 8;
  localparam int SW = 3;

  logic            clk = 1'b0;
  logic            rst, en_n, mode, start, z_ready;
  logic [SW-1:0]   sel;
  logic [CH*W-1:0] data_in;
  logic [W-1:0]    z, z_n;
  logic            z_valid, busy, done;
  logic [SW-1:0]   ch;

  mux_scan_sel #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clk(clk), .rst(rst), .en_n(en_n), .mode(mode), .sel(sel),
    .start(start), .data_in(data_in), .z(z), .z_n(z_n),
    .z_valid(z_valid), .z_ready(z_ready), .ch(ch), .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0]  z;
    logic          zv;
    logic [SW-1:0] ch;
    logic          busy;
    logic          done;
  } exp_t;

  typedef struct {
    int           c;
    logic [W-1:0] w;
  } word_t;

  exp_t  exp_q[$];
  int    errors = 0;
  int    checks = 0;

  // Reference model: a scan is a queue of pending (channel, word) pairs.
  word_t        pend[$];
  bit           scanning = 0;
  logic [W-1:0] m_z = '0;
  logic         m_zv = 0, m_busy = 0, m_done = 0;
  int           m_ch = 0;

  task automatic model_step();
    exp_t e;
    word_t wd;
    if (rst) begin
      pend.delete();
      scanning = 0; m_z = '0; m_zv = 0; m_ch = 0; m_busy = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (scanning) begin
        if (en_n) begin
          pend.delete();
          scanning = 0; m_z = '0; m_zv = 0; m_busy = 0;
        end else if (z_ready) begin
          void'(pend.pop_front());
          if (pend.size() == 0) begin
            scanning = 0; m_z = '0; m_zv = 0; m_busy = 0; m_done = 1;
          end else begin
            m_z = pend[0].w; m_ch = pend[0].c;
          end
        end
      end else begin
        if (en_n) begin
          m_z = '0; m_zv = 0;
        end else if (!mode) begin
          m_z  = (int'(sel) < CH) ? data_in[int'(sel)*W +: W] : '0;
          m_ch = int'(sel); m_zv = 1;
        end else if (!start) begin
          m_z = '0; m_zv = 0;
        end else begin
          for (int i = 0; i < CH; i++) begin
            wd.c = i; wd.w = data_in[i*W +: W];
            pend.push_back(wd);
          end
          scanning = 1; m_z = pend[0].w; m_ch = 0; m_zv = 1; m_busy = 1;
        end
      end
    end
    e.z = m_z; e.zv = m_zv; e.ch = SW'(m_ch); e.busy = m_busy; e.done = m_done;
    exp_q.push_back(e);
  endtask

  // One clock: model the edge, apply it, then move inputs off the edge.
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (z !== e.z || z_n !== ~e.z || z_valid !== e.zv || ch !== e.ch ||
          busy !== e.busy || done !== e.done) begin
        errors++;
        $display("FAIL out t=%0t got z=%h z_n=%h v=%b ch=%0d busy=%b done=%b exp z=%h z_n=%h v=%b ch=%0d busy=%b done=%b",
                 $time, z, z_n, z_valid, ch, busy, done,
                 e.z, ~e.z, e.zv, e.ch, e.busy, e.done);
      end
    end
  end

  task automatic fill(input int kind);
    for (int i = 0; i < CH; i++) begin
      if (kind == 0) data_in[i*W +: W] = W'(i + 3);
      else           data_in[i*W +: W] = W'(4'hA ^ i);
    end
  endtask

  task automatic do_start();
    en_n = 0; mode = 1; start = 1; cyc(); start = 0;
  endtask

  initial begin
    rst = 1; en_n = 0; mode = 0; sel = '0; start = 0; z_ready = 0;
    data_in = {$urandom, $urandom} ;

    // Reset with random inputs
    for (int i = 0; i < 2; i++) begin
      en_n = 1'($urandom); mode = 1'($urandom); sel = SW'($urandom);
      start = 1'($urandom); z_ready = 1'($urandom); data_in = $urandom;
      cyc();
    end
    rst = 0; start = 0;

    // Direct sweep, then disable
    fill(0); en_n = 0; mode = 0;
    for (int s = 0; s < CH; s++) begin sel = SW'(s); cyc(); end
    en_n = 1; cyc(); cyc();

    // Scan without backpressure
    fill(1); z_ready = 1; do_start();
    for (int i = 0; i < 10; i++) cyc();

    // Backpressure at ch=2 with data changing after start
    fill(1); z_ready = 1; do_start();
    data_in = '0;
    cyc(); cyc();
    z_ready = 0; cyc(); cyc(); cyc();
    z_ready = 1;
    for (int i = 0; i < 8; i++) cyc();

    // Abort at ch=5, then a fresh scan
    fill(1); z_ready = 1; do_start();
    for (int i = 0; i < 5; i++) cyc();
    en_n = 1; cyc(); cyc();
    do_start();
    for (int i = 0; i < 9; i++) cyc();

    // Mid-scan reset, then start held high while busy
    fill(0); z_ready = 1; do_start();
    for (int i = 0; i < 3; i++) cyc();
    rst = 1; cyc(); rst = 0;
    do_start(); start = 1;
    for (int i = 0; i < 12; i++) cyc();
    start = 0;

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(0, 199) == 0);
      en_n    = ($urandom_range(0, 19) == 0);
      mode    = ($urandom_range(0, 3) != 0);
      sel     = SW'($urandom);
      start   = ($urandom_range(0, 3) == 0);
      z_ready = ($urandom_range(0, 2) != 0);
      data_in = {$urandom, $urandom};
      cyc();
    end

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
